// File: rtl/bitonic_16_sched.sv
// Batch scheduler in front of the 16-input bitonic sorter: gathers a serial stream
// into padded batches, launches one at a time, captures results, watches for lost ones.
module bitonic_16_sched #(
  parameter int                   DATAWIDTH  = 8,
  parameter int                   DATALENGTH = 16,
  parameter logic [DATAWIDTH-1:0] PAD_VALUE  = '0,
  parameter int                   MAX_LAT    = 16,
  parameter int                   CW         = $clog2(DATALENGTH+1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [DATAWIDTH-1:0]                  in_data_i,
  input  logic                                  in_last_i,
  output logic                                  sort_valid_o,
  output logic [DATALENGTH-1:0][DATAWIDTH-1:0]  sort_x_o,
  input  logic                                  sort_valid_i,
  input  logic [DATALENGTH-1:0][DATAWIDTH-1:0]  sort_y_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [DATALENGTH-1:0][DATAWIDTH-1:0]  out_data_o,
  output logic [CW-1:0]                         out_count_o,
  output logic [1:0]                            err_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never waits on ready, and data is held stable while valid is high and ready low.

  localparam int WW = $clog2(MAX_LAT+1);

  typedef enum logic {FILL, PEND} state_t;

  state_t                               state;
  logic [DATALENGTH-1:0][DATAWIDTH-1:0] fill_buf;
  logic [CW-1:0]                        fill_cnt;
  logic [CW-1:0]                        flight_cnt;
  logic                                 in_flight;
  logic [WW-1:0]                        wd_cnt;
  logic                                 accept;
  logic                                 close;
  logic                                 launch;
  logic                                 capture;
  logic                                 timeout;

  // Ready depends only on state, so downstream stalls never ripple into the input side.
  assign in_ready_o = (state == FILL) && !rst_i;
  assign accept     = in_valid_i && in_ready_o;
  assign close      = accept && (in_last_i || (fill_cnt == CW'(DATALENGTH-1)));
  assign launch     = (state == PEND) && !in_flight && (!out_valid_o || out_ready_i);
  assign capture    = sort_valid_i && in_flight;
  assign timeout    = in_flight && !sort_valid_i && (wd_cnt == WW'(MAX_LAT-1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= FILL;
      fill_buf     <= '0;
      fill_cnt     <= '0;
      flight_cnt   <= '0;
      in_flight    <= 1'b0;
      wd_cnt       <= '0;
      sort_valid_o <= 1'b0;
      sort_x_o     <= '0;
      out_valid_o  <= 1'b0;
      out_data_o   <= '0;
      out_count_o  <= '0;
      err_o        <= '0;
    end else begin
      sort_valid_o <= 1'b0;

      // Closing accept pads every slot above the one being written.
      for (int k = 0; k < DATALENGTH; k++) begin
        if (accept && (CW'(k) == fill_cnt)) fill_buf[k] <= in_data_i;
        else if (close && (CW'(k) > fill_cnt)) fill_buf[k] <= PAD_VALUE;
      end

      case (state)
        FILL: begin
          if (accept) fill_cnt <= fill_cnt + 1'b1;
          if (close)  state    <= PEND;
        end
        PEND: begin
          if (launch) begin
            state        <= FILL;
            fill_cnt     <= '0;
            sort_x_o     <= fill_buf;
            sort_valid_o <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase

      // Capture wins over a timeout landing in the same cycle.
      if (launch) begin
        in_flight  <= 1'b1;
        wd_cnt     <= '0;
        flight_cnt <= fill_cnt;
      end else if (capture) begin
        in_flight   <= 1'b0;
        out_data_o  <= sort_y_i;
        out_count_o <= flight_cnt;
      end else if (timeout) begin
        in_flight <= 1'b0;
        err_o[0]  <= 1'b1;
      end else if (in_flight) begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      if (sort_valid_i && !in_flight) err_o[1] <= 1'b1;

      if (capture)          out_valid_o <= 1'b1;
      else if (out_ready_i) out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bitonic_16_sched.sv
// Bench for bitonic_16_sched: a behavioural sorter model with adjustable latency/drop,
// and a scoreboard of expected launches and results built from the driven stimulus.
module tb_bitonic_16_sched;

  localparam int DW = 8;
  localparam int DL = 16;
  localparam int CW = 5;

  typedef logic [DL-1:0][DW-1:0] vec_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i = '0;
  logic          in_last_i = 1'b0;
  logic          sort_valid_o;
  vec_t          sort_x_o;
  logic          sort_valid_i;
  vec_t          sort_y_i;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  vec_t          out_data_o;
  logic [CW-1:0] out_count_o;
  logic [1:0]    err_o;

  bitonic_16_sched #(.DATAWIDTH(DW), .DATALENGTH(DL), .PAD_VALUE('0), .MAX_LAT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_last_i(in_last_i),
    .sort_valid_o(sort_valid_o), .sort_x_o(sort_x_o),
    .sort_valid_i(sort_valid_i), .sort_y_i(sort_y_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_count_o(out_count_o), .err_o(err_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic vec_t sort_vec(input vec_t v);
    vec_t r = v;
    logic [DW-1:0] t;
    for (int i = 0; i < DL-1; i++)
      for (int j = 0; j < DL-1-i; j++)
        if (r[j] > r[j+1]) begin
          t = r[j]; r[j] = r[j+1]; r[j+1] = t;
        end
    return r;
  endfunction

  // ---------------- scoreboard + sorter model ----------------
  vec_t          exp_x_q[$];
  logic [CW-1:0] exp_xc_q[$];
  vec_t          exp_y_q[$];
  logic [CW-1:0] exp_yc_q[$];

  logic model_v = 1'b0;
  logic inj_v   = 1'b0;
  vec_t model_y = '0;
  vec_t pend_y  = '0;
  int   pend_cnt = 0;
  int   model_lat = 4;
  bit   drop_next = 1'b0;
  int   n_launch = 0;
  int   launch_cyc = 0;
  int   last_acc_cyc = 0;

  assign sort_valid_i = model_v | inj_v;
  assign sort_y_i     = inj_v ? vec_t'('0) : model_y;

  always @(negedge clk_i) begin
    vec_t          ex;
    logic [CW-1:0] ec;
    model_v = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        model_v = 1'b1;
        model_y = pend_y;
      end
    end
    if (sort_valid_o) begin
      n_launch++;
      launch_cyc = cyc;
      if (exp_x_q.size() == 0) begin
        check_eq("unexpected_launch", sort_valid_o, 1'b0);
      end else begin
        ex = exp_x_q.pop_front();
        ec = exp_xc_q.pop_front();
        check_eq("sort_x", sort_x_o, ex);
        if (!drop_next) begin
          exp_y_q.push_back(sort_vec(ex));
          exp_yc_q.push_back(ec);
        end
      end
      if (drop_next) drop_next = 1'b0;
      else begin
        pend_y   = sort_vec(sort_x_o);
        pend_cnt = model_lat;
      end
    end
    if (out_valid_o && out_ready_i) begin
      if (exp_y_q.size() == 0) begin
        check_eq("unexpected_out", out_valid_o, 1'b0);
      end else begin
        check_eq("out_data", out_data_o, exp_y_q.pop_front());
        check_eq("out_count", out_count_o, exp_yc_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [DW-1:0] vals [DL];

  task automatic fill_rand();
    for (int i = 0; i < DL; i++) vals[i] = DW'($urandom_range(0, 255));
  endtask

  task automatic wait_accept();
    bit acc;
    int g = 0;
    do begin
      @(negedge clk_i);
      acc = in_ready_o;
      @(posedge clk_i);
      #1;
      g++;
    end while (!acc && g < 200);
    if (!acc) check_eq("accept_timeout", acc, 1'b1);
  endtask

  task automatic send_batch(input int n, input bit last_at_end);
    vec_t x = '0;
    for (int i = 0; i < n; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = vals[i];
      in_last_i  = last_at_end && (i == n-1);
      wait_accept();
      x[i] = vals[i];
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    last_acc_cyc = cyc;
    exp_x_q.push_back(x);
    exp_xc_q.push_back(CW'(n));
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((exp_x_q.size() != 0 || exp_y_q.size() != 0) && g < 300) begin
      @(negedge clk_i);
      g++;
    end
    check_eq("idle_timeout", (g < 300), 1'b1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_err(input int bitn);
    int g = 0;
    while (!err_o[bitn] && g < 60) begin
      @(negedge clk_i);
      g++;
    end
    check_eq("err_wait_timeout", err_o[bitn], 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_in_ready", in_ready_o, 1'b0);
    check_eq("rst_sort_valid", sort_valid_o, 1'b0);
    check_eq("rst_out_valid", out_valid_o, 1'b0);
    check_eq("rst_err", err_o, 2'b00);
    check_eq("rst_out_count", out_count_o, '0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("post_rst_in_ready", in_ready_o, 1'b1);
    @(posedge clk_i); #1;

    // Full descending batch
    base = n_launch;
    for (int i = 0; i < DL; i++) vals[i] = DW'(15 - i);
    send_batch(16, 1'b0);
    wait_idle();
    check_eq("t1_launch_latency", launch_cyc - last_acc_cyc, 1);
    check_eq("t1_launch_count", n_launch - base, 1);

    // Short batch with padding
    vals[0] = 8'd9; vals[1] = 8'd3; vals[2] = 8'd7; vals[3] = 8'd1; vals[4] = 8'd5;
    send_batch(5, 1'b1);
    wait_idle();

    // Three batches under backpressure
    out_ready_i = 1'b0;
    base = n_launch;
    fill_rand(); send_batch(16, 1'b0);
    fill_rand(); send_batch(16, 1'b1);
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("t3_b2_held", n_launch - base, 1);
    check_eq("t3_in_ready_pend", in_ready_o, 1'b0);
    check_eq("t3_out_held", out_valid_o, 1'b1);
    @(posedge clk_i); #1 out_ready_i = 1'b1;
    @(posedge clk_i); #1 out_ready_i = 1'b0;
    fill_rand(); send_batch(16, 1'b0);
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("t3_b3_held", n_launch - base, 2);
    check_eq("t3_in_ready_pend3", in_ready_o, 1'b0);
    check_eq("t3_out_held2", out_valid_o, 1'b1);
    @(posedge clk_i); #1 out_ready_i = 1'b1;
    wait_idle();

    // Lost sorter result
    drop_next = 1'b1;
    fill_rand(); send_batch(16, 1'b0);
    wait_idle();
    wait_err(0);
    check_eq("t4_timeout_cycles", cyc - launch_cyc, 16);
    check_eq("t4_err", err_o, 2'b01);
    check_eq("t4_no_out", out_valid_o, 1'b0);
    @(posedge clk_i); #1;
    fill_rand(); send_batch(7, 1'b1);
    wait_idle();

    // Spurious sorter valid
    inj_v = 1'b1;
    @(posedge clk_i); #1 inj_v = 1'b0;
    @(negedge clk_i);
    check_eq("t5_err", err_o, 2'b11);
    check_eq("t5_no_out", out_valid_o, 1'b0);
    @(posedge clk_i); #1;

    // Reset mid-fill with a batch in flight
    model_lat = 12;
    fill_rand(); send_batch(16, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = DW'($urandom_range(0, 255));
      wait_accept();
    end
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    exp_x_q.delete(); exp_xc_q.delete(); exp_y_q.delete(); exp_yc_q.delete();
    @(negedge clk_i);
    check_eq("t6_in_ready", in_ready_o, 1'b0);
    check_eq("t6_sort_valid", sort_valid_o, 1'b0);
    check_eq("t6_sort_x", sort_x_o, '0);
    check_eq("t6_out_valid", out_valid_o, 1'b0);
    check_eq("t6_out_data", out_data_o, '0);
    check_eq("t6_out_count", out_count_o, '0);
    check_eq("t6_err", err_o, 2'b00);
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("t6_post_in_ready", in_ready_o, 1'b1);
    wait_err(1);
    check_eq("t6_stray_err", err_o, 2'b10);
    check_eq("t6_stray_no_out", out_valid_o, 1'b0);
    repeat (3) @(negedge clk_i);
    check_eq("t6_stray_no_out_late", out_valid_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitonic_16_sched.md
Name: bitonic_16_sched

Overview:
Batch scheduler that sits in front of the 16-input bitonic sorter and owns its launch sequencing. It collects a serial valid/ready stream into DATALENGTH-wide batches and pads short batches. It launches one batch at a time into the sorter pipeline, then captures the sorted vector and presents it downstream with backpressure. A watchdog detects lost sorter results.

Parameters:
DATAWIDTH, 8, element width in bits
DATALENGTH, 16, elements per batch (sorter width); power of 2, ≥2
PAD_VALUE, 0, fill value for unused slots of a short batch
MAX_LAT, 16, watchdog limit in cycles from launch to sort_valid_i; ≥1
CW, $clog2(DATALENGTH+1), count width (derived)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
in_valid_i  in  1  input element valid
in_ready_o  out  1  input element accepted when in_valid_i&in_ready_o
in_data_i  in  DATAWIDTH  input element
in_last_i  in  1  closes the current batch after this element
sort_valid_o  out  1  one-cycle launch strobe to the sorter
sort_x_o  out  DATALENGTH x DATAWIDTH  batch to the sorter; index k = k-th accepted element
sort_valid_i  in  1  sorter result valid (sorter output ctrl valid)
sort_y_i  in  DATALENGTH x DATAWIDTH  sorted vector from the sorter
out_valid_o  out  1  result valid
out_ready_i  in  1  result consumed when out_valid_o&out_ready_i
out_data_o  out  DATALENGTH x DATAWIDTH  captured sorted vector
out_count_o  out  CW  real (non-pad) elements in this result, 1..DATALENGTH
err_o  out  2  sticky flags: [0] watchdog timeout, [1] spurious sort_valid_i

Behaviour:
- Reset: in_ready_o=0 during reset and 1 in the first cycle after reset. sort_valid_o=0, out_valid_o=0, err_o=0, sort_x_o/out_data_o/out_count_o=0. Fill count=0, in-flight=0, watchdog=0. Reset mid-batch discards all buffered and in-flight data. A sort_valid_i arriving after reset is treated as spurious.
- Fill buffer and state:
  - FILL: accepts elements; fill count increments on each accept.
  - The batch closes on the accept that makes the count DATALENGTH, or on any accept with in_last_i=1. Both together close it once.
  - On close, slots count..DATALENGTH-1 are written PAD_VALUE, and the state moves to PEND with the count latched.
  - In PEND, in_ready_o=0.
- Launch condition (evaluated in PEND): in-flight=0 AND (out_valid_o=0 OR out_valid_o&out_ready_i this cycle).
  - On launch, sort_x_o is registered and sort_valid_o=1 for exactly one cycle.
  - Also on launch: in-flight=1, watchdog=0, batch count copied to an in-flight count register, fill count=0, state returns to FILL.
  - Launch happens the cycle after the closing accept at the earliest.
  - sort_x_o holds until the next launch.
- FILL of the next batch proceeds while a batch is in flight. At most one batch is in flight and at most one result is held.
- Capture on sort_valid_i & in-flight=1:
  - Register sort_y_i into out_data_o and the in-flight count into out_count_o.
  - Set out_valid_o=1 the next cycle and clear in-flight.
  - The launch condition guarantees the result slot is free.
- Output handshake: out_valid_o stays high until out_ready_i; out_data_o/out_count_o are stable while valid. Capture and drain in the same cycle is legal: the new result replaces the old one and out_valid_o stays 1.
- Watchdog:
  - Counts while in-flight=1.
  - If it reaches MAX_LAT without sort_valid_i: set err_o[0], clear in-flight, drop the batch, no output.
  - sort_valid_i in the same cycle the watchdog reaches MAX_LAT counts as a capture, not a timeout.
- sort_valid_i with in-flight=0: ignored, set err_o[1].
- err_o bits clear only on reset.
- No combinational path from sort_valid_i or out_ready_i to in_ready_o.

Test Plan:
- DATALENGTH=16, 16 elements 15,14..0 streamed back-to-back; sorter model with latency 4 → one sort_valid_o pulse the cycle after the 16th accept, sort_x_o[k]=15-k, out_count_o=16, out_data_o equals model output.
- 5 elements 9,3,7,1,5 with in_last_i on the 5th, PAD_VALUE=0 → sort_x_o[0..4]=9,3,7,1,5, sort_x_o[5..15]=0, out_count_o=5.
- Three full batches back-to-back, out_ready_i held 0 → batch 1 result held; batch 2 launches only after out_ready_i pulses; in_ready_o=0 while batch 3 is in PEND; no data lost or reordered.
- Sorter model drops a result, MAX_LAT=16 → err_o[0]=1 exactly 16 cycles after launch, no out_valid_o; the next batch then launches and completes normally.
- sort_valid_i pulsed with nothing in flight → err_o[1]=1, out_valid_o stays 0.
- Assert rst_i midway through filling batch 2 while batch 1 is in flight → all outputs at reset values the next cycle; a later stray sort_valid_i sets err_o[1] only.
